// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg: command encodings, FSM state type and counter sizing helper  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_pkg;

    localparam logic [1:0] c_OP_WR_ADDR = 2'b00;
    localparam logic [1:0] c_OP_WR_DATA = 2'b01;
    localparam logic [1:0] c_OP_RD_ADDR = 2'b10;
    localparam logic [1:0] c_OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RWBIT = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RECV  = 3'd5,
        ST_HOLD  = 3'd6,
        ST_GAP   = 3'd7
    } spi_state_t;

    // Counters run 0..len-1, so the longest phase needs clog2(len) bits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_shift_reg: parallel-load/serial-out and serial-in/parallel-out    |
// | shift register, MSB first.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_shift_reg #(
    parameter int WIDTH = 10,
    parameter int RX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_en,
    input  logic             i_serial_in,
    output logic             o_serial_out,
    output logic [RX_W-1:0]  o_rx_word
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_load_data;
        end else if (i_shift_en) begin
            r_sreg <= {r_sreg[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_serial_out = r_sreg[WIDTH-1];
    // Word as it will stand once the bit currently on i_serial_in is shifted in.
    assign o_rx_word    = {r_sreg[RX_W-2:0], i_serial_in};

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_ctrl: command-driven SPI master framing address/data      |
// | writes and reads. Optional SPI_MASTER_TXN_CNT_EN adds txn_cnt.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int IDLE_GAP = 3,
    parameter int RD_WAIT  = 2,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_byte,
    output logic              MOSI,
    output logic              SS_n,
    input  logic              MISO,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
`ifdef SPI_MASTER_TXN_CNT_EN
    ,
    output logic [15:0]       txn_cnt
`endif
);

    localparam int c_CNT_W = cnt_width(DATA_W + 2, RD_WAIT, IDLE_GAP);
    localparam logic [c_CNT_W-1:0] c_SHIFT_LAST = c_CNT_W'(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(RD_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_RECV_LAST  = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(IDLE_GAP - 1);

    spi_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_op;
    logic               w_load;
    logic               w_shift_en;
    logic               w_so;
    logic [DATA_W-1:0]  w_rx_word;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign w_load    = cmd_ready && cmd_valid;
    // RWBIT pre-shifts so MOSI can be registered straight from the MSB each SHIFT cycle.
    assign w_shift_en = (r_state == ST_RWBIT) ||
                        ((r_state == ST_SHIFT) && (r_cnt != c_SHIFT_LAST)) ||
                        (r_state == ST_RECV);

    spi_shift_reg #(
        .WIDTH (DATA_W + 2),
        .RX_W  (DATA_W)
    ) u_shift_reg (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_load_data  ({cmd_op, cmd_byte}),
        .i_shift_en   (w_shift_en),
        .i_serial_in  (MISO),
        .o_serial_out (w_so),
        .o_rx_word    (w_rx_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_cnt   <= '0;
                        SS_n    <= 1'b0;
                        MOSI    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    MOSI    <= r_op[1];
                    r_state <= ST_RWBIT;
                end
                ST_RWBIT: begin
                    MOSI    <= w_so;
                    r_cnt   <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_cnt == c_SHIFT_LAST) begin
                        MOSI    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= (r_op == c_OP_RD_DATA) ? ST_WAIT : ST_HOLD;
                    end else begin
                        MOSI  <= w_so;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_RECV;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RECV: begin
                    if (r_cnt == c_RECV_LAST) begin
                        rd_data  <= w_rx_word;
                        rd_valid <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    SS_n    <= 1'b1;
                    MOSI    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    SS_n    <= 1'b1;
                    MOSI    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_TXN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt <= '0;
        end else if ((r_state == ST_GAP) && (r_cnt == c_GAP_LAST)) begin
            txn_cnt <= txn_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_master_ctrl: frame-level reference model plus SPI slave model  |
// | checked against spi_master_ctrl every cycle. Revision: 1.0            |
// +----------------------------------------------------------------------+
module tb_spi_master_ctrl;

    localparam int c_GAP = 3;
    localparam int c_RDW = 2;
    localparam int c_DW  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_byte = 8'h00;
    logic       MOSI;
    logic       SS_n;
    logic       MISO = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
`ifdef SPI_MASTER_TXN_CNT_EN
    logic [15:0] txn_cnt;
`endif

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .IDLE_GAP (c_GAP),
        .RD_WAIT  (c_RDW),
        .DATA_W   (c_DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_byte  (cmd_byte),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy)
`ifdef SPI_MASTER_TXN_CNT_EN
        ,
        .txn_cnt   (txn_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct packed {
        logic       ss;
        logic       mosi;
        logic       rv;
        logic [7:0] rd;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_rd = 8'h00;
    int         m_txn = 0;
    int         n_acc = 0;

    function automatic exp_t mk(input logic ss, input logic mosi, input logic rv, input logic [7:0] rd);
        exp_t e;
        e.ss = ss; e.mosi = mosi; e.rv = rv; e.rd = rd;
        return e;
    endfunction

    task automatic push_frame(input logic [1:0] op, input logic [7:0] b);
        logic [9:0] w;
        w = {op, b};
        q.push_back(mk(1'b0, 1'b0, 1'b0, m_rd));
        q.push_back(mk(1'b0, op[1], 1'b0, m_rd));
        for (int i = 9; i >= 0; i--) q.push_back(mk(1'b0, w[i], 1'b0, m_rd));
        if (op == 2'b11) begin
            for (int i = 0; i < c_RDW + c_DW; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, m_rd));
            m_rd = m_mem[m_addr];
            q.push_back(mk(1'b0, 1'b0, 1'b1, m_rd));
        end else begin
            if (op == 2'b01) m_mem[m_addr] = b;
            else m_addr = b;
            q.push_back(mk(1'b0, 1'b0, 1'b0, m_rd));
        end
        for (int i = 0; i < c_GAP; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, m_rd));
    endtask

    initial for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    always @(posedge clk) begin
        exp_t tmp;
        if (rst) begin
            q.delete();
            m_rd  = 8'h00;
            m_txn = 0;
        end else if (q.size() > 0) begin
            tmp = q.pop_front();
            if (q.size() == 0) m_txn++;
        end else if (cmd_valid) begin
            push_frame(cmd_op, cmd_byte);
            n_acc++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   idle;
        if (chk_en) begin
            idle = (q.size() == 0);
            e = idle ? mk(1'b1, 1'b0, 1'b0, m_rd) : q[0];
            chk("ss_n", SS_n, e.ss);
            chk("mosi", MOSI, e.mosi);
            chk("rd_valid", rd_valid, e.rv);
            chk("rd_data", rd_data, e.rd);
            chk("cmd_ready", cmd_ready, idle);
            chk("busy", busy, !idle);
`ifdef SPI_MASTER_TXN_CNT_EN
            chk("txn_cnt", txn_cnt, m_txn);
`endif
        end
    end

    // ---------------- SPI slave: decodes MOSI, answers reads on MISO ----------------
    logic [7:0] s_mem [256];
    logic [7:0] s_addr = 8'h00;
    logic [7:0] s_rd = 8'h00;
    logic [9:0] s_frame = '0;
    logic [1:0] s_op = 2'b00;
    int         s_cnt = 0;

    initial for (int i = 0; i < 256; i++) s_mem[i] = 8'h00;

    always @(negedge clk) begin
        int pos;
        if (SS_n === 1'b0) begin
            pos = s_cnt;
            s_cnt++;
            if (pos == 0) s_op = 2'b00;
            if (pos >= 2 && pos <= 11) s_frame = {s_frame[8:0], MOSI};
            if (pos == 11) begin
                s_op = s_frame[9:8];
                case (s_op)
                    2'b01:   s_mem[s_addr] = s_frame[7:0];
                    2'b11:   s_rd = s_mem[s_addr];
                    default: s_addr = s_frame[7:0];
                endcase
            end
            if (s_op == 2'b11 && pos >= 12 + c_RDW && pos < 12 + c_RDW + c_DW)
                MISO = s_rd[c_DW - 1 - (pos - 12 - c_RDW)];
            else
                MISO = 1'b0;
        end else begin
            s_cnt = 0;
            MISO  = 1'b0;
        end
    end

    // ---------------- bus measurements for literal checks ----------------
    int          lo_cnt = 0, hi_cnt = 0, last_len = 0, hi_last = 0, rv_pulses = 0;
    logic [31:0] lo_bits = '0, last_bits = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (SS_n === 1'b0) begin
                if (lo_cnt == 0) hi_last = hi_cnt;
                hi_cnt  = 0;
                lo_cnt++;
                lo_bits = {lo_bits[30:0], MOSI};
            end else begin
                if (lo_cnt != 0) begin
                    last_len  = lo_cnt;
                    last_bits = lo_bits;
                end
                lo_cnt  = 0;
                lo_bits = '0;
                hi_cnt++;
            end
            if (rd_valid === 1'b1) rv_pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_acc(input int start);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (n_acc != start) break;
        end
        if (k == 100) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] b);
        @(negedge clk);
        cmd_op = op; cmd_byte = b; cmd_valid = 1'b1;
        wait_acc(n_acc);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (k == 200) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int a0, rv0;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", SS_n, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 1'b0);
        rst = 1'b0;

        send(2'b00, 8'hA9);
        wait_idle();
        chk("wa_len", last_len, 13);
        chk("wa_bits", last_bits, 32'h0000_0152);
        chk("slave_addr", s_addr, 8'hA9);

        send(2'b01, 8'hF1);
        wait_idle();
        chk("wd_len", last_len, 13);
        chk("slave_mem_a9", s_mem[8'hA9], 8'hF1);

        send(2'b10, 8'hA9);
        wait_idle();
        rv0 = rv_pulses;
        send(2'b11, 8'hF1);
        wait_idle();
        chk("rd_len", last_len, 23);
        chk("rd_value", rd_data, 8'hF1);
        chk("rd_pulses", rv_pulses - rv0, 1);

        // Two commands queued behind a continuously asserted cmd_valid.
        @(negedge clk);
        cmd_op = 2'b00; cmd_byte = 8'h3C; cmd_valid = 1'b1;
        a0 = n_acc;
        wait_acc(a0);
        cmd_op = 2'b01; cmd_byte = 8'h55;
        wait_acc(a0 + 1);
        cmd_valid = 1'b0;
        wait_idle();
        chk("queued_gap", hi_last, c_GAP + 1);
        chk("slave_mem_3c", s_mem[8'h3C], 8'h55);
        chk("rd_hold", rd_data, 8'hF1);
`ifdef SPI_MASTER_TXN_CNT_EN
        chk("txn_total", txn_cnt, 16'd6);
`endif

        do_reset(2);
        chk("rst2_rd_data", rd_data, 8'h00);
        rv0 = rv_pulses;
        send(2'b11, 8'h00);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ss_n", SS_n, 1'b1);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_len", last_len, 7);
        chk("abort_no_rv", rv_pulses - rv0, 0);
        chk("abort_rd_data", rd_data, 8'h00);
`ifdef SPI_MASTER_TXN_CNT_EN
        chk("abort_txn", txn_cnt, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
